ex_stage_mc: RTL and testbench

//  Parametrised execute stage, successor to the single-cycle EX: the ALU plus a branch/jump target adder,

---
 rtl/ex_stage_mc_pkg.sv | 31 +++
 rtl/ex_stage_mc_alu.sv | 50 +++++
 rtl/ex_stage_mc.sv | 134 +++++++++++++
 tb/tb_ex_stage_mc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_mc_pkg.sv
// Shared encodings for the execute stage: ALU op codes, branch opcodes, flag layout, FSM states.
package ex_stage_mc_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_NOR = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SRA = 4'd6;
    localparam logic [3:0] ALU_MUL = 4'd7;

    localparam logic [3:0] OPC_B  = 4'hA;
    localparam logic [3:0] OPC_JR = 4'hB;

    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    function automatic logic [2:0] pack_flags(input logic n, input logic z, input logic v);
        logic [2:0] f;
        f         = 3'b000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/ex_stage_mc_alu.sv
// Combinational single-cycle ALU; MUL code falls back to ADD (multi-cycle MUL lives in the top).
module alu_w
    import ex_stage_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [SHW-1:0]   sh_amt,
    output logic [WIDTH-1:0] dst,
    output logic             v,
    output logic             z,
    output logic             n,
    output logic             def
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        dst = '0;
        v   = 1'b0;
        def = 1'b1;
        case (op)
            ALU_ADD, ALU_MUL: begin
                dst = sum;
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                dst = diff;
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: dst = a & b;
            ALU_NOR: dst = ~(a | b);
            ALU_SLL: dst = a << sh_amt;
            ALU_SRL: dst = a >> sh_amt;
            ALU_SRA: dst = WIDTH'($signed(a) >>> sh_amt);
            default: def = 1'b0;
        endcase
    end

    assign z = (dst == '0);
    assign n = dst[WIDTH-1];

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: ALU, target adder, handshaked output register, flag register, iterative shift-add MUL.
module ex_stage_mc
    import ex_stage_mc_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SHW    = 4,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [15:0]      in_instr,
    input  logic [WIDTH-1:0] in_reg1,
    input  logic [WIDTH-1:0] in_reg2,
    input  logic [WIDTH-1:0] in_sext,
    input  logic             in_alu_src,
    input  logic [3:0]       in_alu_op,
    input  logic [SHW-1:0]   in_sh_amt,
    input  logic             in_flag_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_target,
    output logic [2:0]       out_flags
);

    state_t             state;
    logic [WIDTH-1:0]   src1;
    logic [WIDTH-1:0]   alu_dst;
    logic               alu_v, alu_z, alu_n, alu_def;
    logic [WIDTH-1:0]   offset;
    logic [WIDTH-1:0]   target;
    logic               accept;
    logic               is_mul;
    logic               mul_done;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   pend_target;
    logic               pend_flag_we;

    assign src1 = in_alu_src ? in_reg2 : in_sext;

    alu_w #(.WIDTH(WIDTH), .SHW(SHW)) u_alu (
        .a      (in_reg1),
        .b      (src1),
        .op     (in_alu_op),
        .sh_amt (in_sh_amt),
        .dst    (alu_dst),
        .v      (alu_v),
        .z      (alu_z),
        .n      (alu_n),
        .def    (alu_def)
    );

    // Short 9-bit offset for B, 12-bit for everything else; JR jumps to the ALU result.
    assign offset = (in_instr[15:12] == OPC_B)
                  ? {{(WIDTH-9){in_instr[8]}}, in_instr[8:0]}
                  : {{(WIDTH-12){in_instr[11]}}, in_instr[11:0]};
    assign target = (in_instr[15:12] == OPC_JR) ? alu_dst : in_pc + offset + WIDTH'(1);

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign is_mul   = (MUL_EN != 1'b0) && (in_alu_op == ALU_MUL);

    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
    assign mul_done = (state == ST_MUL) && (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_target   <= '0;
            out_flags    <= 3'b000;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            cnt          <= '0;
            pend_target  <= '0;
            pend_flag_we <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && is_mul) begin
                        state        <= ST_MUL;
                        mcand        <= {{WIDTH{1'b0}}, in_reg1};
                        mplier       <= src1;
                        acc          <= '0;
                        cnt          <= '0;
                        pend_target  <= target;
                        pend_flag_we <= in_flag_we;
                    end
                end
                ST_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (mul_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Output register: MUL completion, single-cycle load, or drain on consume.
            if (mul_done) begin
                out_valid  <= 1'b1;
                out_result <= acc_nxt[WIDTH-1:0];
                out_target <= pend_target;
                if (pend_flag_we)
                    out_flags <= pack_flags(acc_nxt[WIDTH-1], acc_nxt[WIDTH-1:0] == '0,
                                            |acc_nxt[2*WIDTH-1:WIDTH]);
            end else if (accept && !is_mul) begin
                out_valid  <= 1'b1;
                out_result <= alu_dst;
                out_target <= target;
                if (in_flag_we && alu_def)
                    out_flags <= pack_flags(alu_n, alu_z, alu_v);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed self-checking bench for ex_stage_mc (WIDTH=16, MUL_EN=1).
module tb_ex_stage_mc;
    import ex_stage_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_pc = '0;
    logic [15:0] in_instr = '0;
    logic [15:0] in_reg1 = '0;
    logic [15:0] in_reg2 = '0;
    logic [15:0] in_sext = '0;
    logic        in_alu_src = 1'b1;
    logic [3:0]  in_alu_op = '0;
    logic [3:0]  in_sh_amt = '0;
    logic        in_flag_we = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [15:0] out_target;
    logic [2:0]  out_flags;

    int n_chk  = 0;
    int n_fail = 0;
    int low_cnt;
    int seen;

    always #5 clk = ~clk;

    ex_stage_mc #(.WIDTH(16), .SHW(4), .MUL_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .in_reg1    (in_reg1),
        .in_reg2    (in_reg2),
        .in_sext    (in_sext),
        .in_alu_src (in_alu_src),
        .in_alu_op  (in_alu_op),
        .in_sh_amt  (in_sh_amt),
        .in_flag_we (in_flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_target (out_target),
        .out_flags  (out_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setop(input logic [3:0] op, input logic [15:0] r1, input logic [15:0] r2,
                         input logic [15:0] sx, input logic src, input logic fwe,
                         input logic [15:0] pc, input logic [15:0] instr, input logic [3:0] sh);
        in_alu_op  = op;
        in_reg1    = r1;
        in_reg2    = r2;
        in_sext    = sx;
        in_alu_src = src;
        in_flag_we = fwe;
        in_pc      = pc;
        in_instr   = instr;
        in_sh_amt  = sh;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] r1, input logic [15:0] r2,
                         input logic [15:0] sx, input logic src, input logic fwe,
                         input logic [15:0] pc, input logic [15:0] instr, input logic [3:0] sh);
        setop(op, r1, r2, sx, src, fwe, pc, instr, sh);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_flags", 32'(out_flags), 32'h0);
        chk("rst_result", 32'(out_result), 32'h0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // ADD overflow 0x7FFF+1
        issue(ALU_ADD, 16'h7FFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h0000, 4'd0);
        chk("add_valid", 32'(out_valid), 32'h1);
        chk("add_result", 32'(out_result), 32'h8000);
        chk("add_flags", 32'(out_flags), 32'b101);
        chk("add_target", 32'(out_target), 32'h0101);

        // Back-to-back SUB then AND without flag write
        chk("b2b_ready0", 32'(in_ready), 32'h1);
        issue(ALU_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0);
        chk("sub_result", 32'(out_result), 32'h0000);
        chk("sub_flags", 32'(out_flags), 32'b010);
        chk("b2b_ready1", 32'(in_ready), 32'h1);
        issue(ALU_AND, 16'h0FF0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0);
        chk("and_result", 32'(out_result), 32'h00F0);
        chk("and_flags_hold", 32'(out_flags), 32'b010);

        // Logic and shift ops
        issue(ALU_NOR, 16'h0F0F, 16'h00FF, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0);
        chk("nor_result", 32'(out_result), 32'hF000);
        chk("nor_flags", 32'(out_flags), 32'b100);
        issue(ALU_SLL, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd4);
        chk("sll_result", 32'(out_result), 32'h0030);
        issue(ALU_SRL, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd3);
        chk("srl_result", 32'(out_result), 32'h1000);
        issue(ALU_SRA, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd3);
        chk("sra_result", 32'(out_result), 32'hF000);
        issue(ALU_SUB, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0);
        chk("subv_result", 32'(out_result), 32'h7FFF);
        chk("subv_flags", 32'(out_flags), 32'b001);
        issue(4'hF, 16'h1234, 16'h1111, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0);
        chk("undef_result", 32'(out_result), 32'h0000);
        chk("undef_flags_hold", 32'(out_flags), 32'b001);
        issue(ALU_ADD, 16'h0005, 16'hFFFF, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0);
        chk("sext_src", 32'(out_result), 32'h0015);

        // MUL 0x12*0x34
        issue(ALU_MUL, 16'h0012, 16'h0034, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0);
        low_cnt = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            if (!in_ready) low_cnt++;
            step();
        end
        chk("mul1_ready_low_cycles", 32'(low_cnt), 32'd16);
        chk("mul1_valid", 32'(out_valid), 32'h1);
        chk("mul1_result", 32'(out_result), 32'h03A8);
        chk("mul1_flags", 32'(out_flags), 32'b000);
        chk("mul1_ready_after", 32'(in_ready), 32'h1);

        // MUL 0x1000*0x0010 -> high half nonzero
        issue(ALU_MUL, 16'h1000, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0);
        for (int i = 0; i < 40 && !out_valid; i++) step();
        chk("mul2_result", 32'(out_result), 32'h0000);
        chk("mul2_flags", 32'(out_flags), 32'b011);

        // Branch / jump targets
        issue(ALU_ADD, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'hA1FE, 4'd0);
        chk("b_target", 32'(out_target), 32'h000F);
        issue(ALU_ADD, 16'h1234, 16'h5555, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hB000, 4'd0);
        chk("jr_target", 32'(out_target), 32'h1234);
        issue(ALU_ADD, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 4'd0);
        chk("wrap_target", 32'(out_target), 32'h0000);

        // Drain, then backpressure for 3 cycles
        step();
        chk("drain_valid", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        issue(ALU_ADD, 16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0);
        setop(ALU_SUB, 16'h0009, 16'h0004, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_result", 32'(out_result), 32'h0003);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("release_new_result", 32'(out_result), 32'h0005);
        chk("release_new_valid", 32'(out_valid), 32'h1);
        step();
        chk("release_consumed", 32'(out_valid), 32'h0);

        // Flush at MUL cycle 5
        issue(ALU_MUL, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0);
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        setop(ALU_ADD, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0);
        in_valid = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_flags", 32'(out_flags), 32'b011);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("flush_no_late_result", 32'(seen), 32'd0);
        chk("flush_flags_late", 32'(out_flags), 32'b011);

        // Reset mid-MUL
        issue(ALU_MUL, 16'h0007, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h0000, 4'd0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmul_valid", 32'(out_valid), 32'h0);
        chk("rstmul_flags", 32'(out_flags), 32'b000);
        chk("rstmul_result", 32'(out_result), 32'h0000);
        chk("rstmul_target", 32'(out_target), 32'h0000);
        chk("rstmul_in_ready", 32'(in_ready), 32'h1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("rstmul_no_late_result", 32'(seen), 32'd0);
        issue(ALU_ADD, 16'h0002, 16'h0002, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 4'd0);
        chk("post_rst_add", 32'(out_result), 32'h0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
